// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the mct request interface: size codes, FSM encodings, owner codes.
package mem_ctrl_pkg;

  localparam logic [1:0] MCT_CU_BYTE = 2'd0;
  localparam logic [1:0] MCT_CU_HALF = 2'd1;
  localparam logic [1:0] MCT_CU_WORD = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_MM = 1'b1;

  // Byte count for a size code; the reserved code 2 falls out as 3 bytes.
  function automatic logic [2:0] cu_bytes(input logic [1:0] cu);
    return {1'b0, cu} + 3'd1;
  endfunction

endpackage

// File: rtl/mct_arb.sv
// Two-way fixed-priority arbiter for the mct interface; MM wins over IF.
module mct_arb (
  input  logic en,
  input  logic if_req,
  input  logic mm_req,
  output logic if_gnt,
  output logic mm_gnt
);

  assign mm_gnt = en & mm_req;
  assign if_gnt = en & if_req & ~mm_req;

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates IF/MM requests and serialises them onto a byte-wide
// synchronous RAM, little-endian. Assumes RAM_AW < ADDR_W.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_mct_e,
  input  logic [ADDR_W-1:0] if_mct_a,
  output logic [31:0]       if_mct_n_o,
  output logic              if_mct_ok,
  input  logic              mm_mct_e,
  input  logic              mm_mct_wr,
  input  logic [1:0]        mm_mct_cu,
  input  logic [ADDR_W-1:0] mm_mct_a,
  input  logic [31:0]       mm_mct_n_i,
  output logic [31:0]       mm_mct_n_o,
  output logic              mm_mct_ok,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr
);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              owner_q, owner_d;
  logic              if_ok_q, if_ok_d;
  logic              mm_ok_q, mm_ok_d;
  logic              if_gnt, mm_gnt;
  logic [ADDR_W-1:0] addr_sum;
  logic              unused_sum_hi;

  mct_arb u_arb (
    .en     (state_q == ST_IDLE),
    .if_req (if_mct_e),
    .mm_req (mm_mct_e),
    .if_gnt (if_gnt),
    .mm_gnt (mm_gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (mm_gnt) begin
          owner_d = OWN_MM;
          base_d  = mm_mct_a;
          wdata_d = mm_mct_n_i;
          n_d     = cu_bytes(mm_mct_cu);
          state_d = mm_mct_wr ? ST_WRITE : ST_READ;
        end else if (if_gnt) begin
          owner_d = OWN_IF;
          base_d  = if_mct_a;
          wdata_d = '0;
          n_d     = cu_bytes(MCT_CU_WORD);
          state_d = ST_READ;
        end
        if (mm_gnt || if_gnt) begin
          cnt_d   = '0;
          rdata_d = '0;
        end
      end
      ST_READ: begin
        // IF may flush its fetch at any point; the partial word is simply dropped.
        if (owner_q == OWN_IF && !if_mct_e) begin
          state_d = ST_IDLE;
        end else begin
          // RAM data lags its address by one cycle, so byte cnt-1 arrives now.
          case (cnt_q)
            3'd1:    rdata_d[7:0]   = ram_din;
            3'd2:    rdata_d[15:8]  = ram_din;
            3'd3:    rdata_d[23:16] = ram_din;
            3'd4:    rdata_d[31:24] = ram_din;
            default: ;
          endcase
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == n_q) state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == n_q - 3'd1) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign if_ok_d = (state_d == ST_DONE) && (state_q != ST_DONE) && (owner_d == OWN_IF);
  assign mm_ok_d = (state_d == ST_DONE) && (state_q != ST_DONE) && (owner_d == OWN_MM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      owner_q <= OWN_IF;
      if_ok_q <= 1'b0;
      mm_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      owner_q <= owner_d;
      if_ok_q <= if_ok_d;
      mm_ok_q <= mm_ok_d;
    end
  end

  // Wrap at 2^ADDR_W first, then keep only the RAM-visible bits.
  assign addr_sum      = base_q + ADDR_W'(cnt_q);
  assign unused_sum_hi = ^addr_sum[ADDR_W-1:RAM_AW];

  always_comb begin
    ram_a    = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    if (state_q == ST_WRITE) begin
      ram_wr   = 1'b1;
      ram_a    = addr_sum[RAM_AW-1:0];
      ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    end else if (state_q == ST_READ && cnt_q < n_q) begin
      ram_a = addr_sum[RAM_AW-1:0];
    end
  end

  assign if_mct_ok  = if_ok_q;
  assign mm_mct_ok  = mm_ok_q;
  assign if_mct_n_o = if_ok_q ? rdata_q : 32'd0;
  assign mm_mct_n_o = mm_ok_q ? rdata_q : 32'd0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table, directed corner sequences, random traffic.
module tb_mem_ctrl;

  localparam int RAM_SZ = 131072;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_mct_e, if_mct_ok, mm_mct_e, mm_mct_wr, mm_mct_ok, ram_wr;
  logic [31:0] if_mct_a, if_mct_n_o, mm_mct_a, mm_mct_n_i, mm_mct_n_o;
  logic [1:0]  mm_mct_cu;
  logic [7:0]  ram_din, ram_dout;
  logic [16:0] ram_a;

  logic [7:0]  ram    [0:RAM_SZ-1];
  logic [7:0]  shadow [0:RAM_SZ-1];

  int tests = 0;
  int fails = 0;

  logic [16:0] trace_a[$];
  logic        trace_wr[$];
  logic [7:0]  trace_dout[$];

  typedef struct {
    bit          is_if;
    bit          wr;
    logic [1:0]  cu;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .if_mct_e   (if_mct_e),
    .if_mct_a   (if_mct_a),
    .if_mct_n_o (if_mct_n_o),
    .if_mct_ok  (if_mct_ok),
    .mm_mct_e   (mm_mct_e),
    .mm_mct_wr  (mm_mct_wr),
    .mm_mct_cu  (mm_mct_cu),
    .mm_mct_a   (mm_mct_a),
    .mm_mct_n_i (mm_mct_n_i),
    .mm_mct_n_o (mm_mct_n_o),
    .mm_mct_ok  (mm_mct_ok),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .ram_a      (ram_a),
    .ram_wr     (ram_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] ram_idx(input logic [31:0] addr, input int i);
    logic [31:0] s;
    s = addr + 32'(i);
    return s[16:0];
  endfunction

  function automatic int nbytes(input logic [1:0] cu);
    return int'(cu) + 1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = shadow[ram_idx(addr, i)];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) shadow[ram_idx(addr, i)] = wd[8*i +: 8];
  endtask

  // Issue one request from an idle controller; lat counts cycles from grant to ok.
  task automatic run_txn(input bit is_if, input bit wr, input logic [1:0] cu,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] data, output int lat);
    bit done;
    done = 1'b0;
    lat  = -1;
    data = 32'd0;
    trace_a.delete();
    trace_wr.delete();
    trace_dout.delete();
    @(negedge clk);
    if (is_if) begin
      if_mct_e = 1'b1;
      if_mct_a = addr;
    end else begin
      mm_mct_e   = 1'b1;
      mm_mct_wr  = wr;
      mm_mct_cu  = cu;
      mm_mct_a   = addr;
      mm_mct_n_i = wd;
    end
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      trace_a.push_back(ram_a);
      trace_wr.push_back(ram_wr);
      trace_dout.push_back(ram_dout);
      check("other_ok_idle", 32'(is_if ? mm_mct_ok : if_mct_ok), 32'd0);
      if (is_if ? if_mct_ok : mm_mct_ok) begin
        done = 1'b1;
        lat  = k;
        data = is_if ? if_mct_n_o : mm_mct_n_o;
      end
    end
    if_mct_e = 1'b0;
    mm_mct_e = 1'b0;
    if (!done) check("txn_timeout", 32'd0, 32'd1);
  endtask

  // Drive through the reference model: expected data and latency come from the rules.
  task automatic model_txn(input string tag, input bit is_if, input bit wr,
                           input logic [1:0] cu, input logic [31:0] addr,
                           input logic [31:0] wd);
    logic [31:0] data, exp;
    int lat, n, wr_cnt;
    n   = is_if ? 4 : nbytes(cu);
    exp = (!is_if && wr) ? 32'd0 : model_read(addr, n);
    run_txn(is_if, wr, cu, addr, wd, data, lat);
    if (!is_if && wr) model_write(addr, n, wd);
    check({tag, "_data"}, data, exp);
    check({tag, "_lat"}, 32'(lat), 32'((!is_if && wr) ? n + 1 : n + 2));
    wr_cnt = 0;
    foreach (trace_wr[i]) if (trace_wr[i]) wr_cnt++;
    check({tag, "_wrcnt"}, 32'(wr_cnt), 32'((!is_if && wr) ? n : 0));
  endtask

  initial begin
    logic [31:0] data, mmdata, ifdata;
    int lat, mm_k, if_k;

    rst = 1'b1;
    if_mct_e = 1'b0; if_mct_a = '0;
    mm_mct_e = 1'b0; mm_mct_wr = 1'b0; mm_mct_cu = '0; mm_mct_a = '0; mm_mct_n_i = '0;
    for (int i = 0; i < RAM_SZ; i++) begin
      ram[i]    = 8'($urandom);
      shadow[i] = ram[i];
    end
    repeat (2) @(negedge clk);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_oks", 32'({if_mct_ok, mm_mct_ok}), 32'd0);
    check("rst_n_o", if_mct_n_o | mm_mct_n_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ram_dout", 32'(ram_dout), 32'd0);

    // 1: MM word read with address trace.
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    for (int i = 0; i < 4; i++) shadow[32'h100 + i] = ram[32'h100 + i];
    run_txn(1'b0, 1'b0, 2'd3, 32'h100, 32'd0, data, lat);
    check("s1_data", data, 32'h44332211);
    check("s1_lat", 32'(lat), 32'd6);
    for (int i = 0; i < 4; i++) check("s1_ram_a", 32'(trace_a[i]), 32'h100 + 32'(i));

    // 2: MM byte write.
    run_txn(1'b0, 1'b1, 2'd0, 32'h7, 32'hAABBCCDD, data, lat);
    model_write(32'h7, 1, 32'hAABBCCDD);
    check("s2_lat", 32'(lat), 32'd2);
    check("s2_wr", 32'(trace_wr[0]), 32'd1);
    check("s2_ram_a", 32'(trace_a[0]), 32'h7);
    check("s2_dout", 32'(trace_dout[0]), 32'hDD);
    check("s2_wr_done", 32'(trace_wr[1]), 32'd0);
    check("s2_n_o", data, 32'd0);
    @(negedge clk);
    check("s2_mem7", 32'(ram[7]), 32'hDD);
    check("s2_mem8", 32'(ram[8]), 32'(shadow[8]));

    // 3: simultaneous requests, MM first.
    @(negedge clk);
    mm_mct_e = 1'b1; mm_mct_wr = 1'b0; mm_mct_cu = 2'd3; mm_mct_a = 32'h100;
    if_mct_e = 1'b1; if_mct_a = 32'h104;
    mm_k = 0; if_k = 0; mmdata = 0; ifdata = 0;
    for (int k = 1; k <= 40 && if_k == 0; k++) begin
      @(negedge clk);
      check("s3_ok_overlap", 32'(mm_mct_ok & if_mct_ok), 32'd0);
      if (mm_mct_ok) begin mm_k = k; mmdata = mm_mct_n_o; mm_mct_e = 1'b0; end
      if (if_mct_ok) begin if_k = k; ifdata = if_mct_n_o; if_mct_e = 1'b0; end
    end
    if_mct_e = 1'b0; mm_mct_e = 1'b0;
    check("s3_mm_k", 32'(mm_k), 32'd6);
    check("s3_if_k", 32'(if_k), 32'd13);
    check("s3_mm_data", mmdata, 32'h44332211);
    check("s3_if_data", ifdata, model_read(32'h104, 4));

    // 4: IF flush at READ cnt=2, then a fresh fetch from the following IDLE cycle.
    @(negedge clk);
    if_mct_e = 1'b1; if_mct_a = 32'h40;
    repeat (3) begin
      @(negedge clk);
      check("s4_no_ok", 32'(if_mct_ok), 32'd0);
    end
    if_mct_e = 1'b0;
    @(negedge clk);
    check("s4_idle_ram_a", 32'(ram_a), 32'd0);
    check("s4_no_ok2", 32'(if_mct_ok), 32'd0);
    if_mct_e = 1'b1; if_mct_a = 32'h80;
    lat = -1; ifdata = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (if_mct_ok) begin lat = k; ifdata = if_mct_n_o; end
    end
    if_mct_e = 1'b0;
    check("s4_lat", 32'(lat), 32'd6);
    check("s4_data", ifdata, model_read(32'h80, 4));

    // 5: half read wrapping the 32-bit address space.
    ram[17'h1FFFF] = 8'h9A; shadow[17'h1FFFF] = 8'h9A;
    ram[0] = 8'hBC; shadow[0] = 8'hBC;
    run_txn(1'b0, 1'b0, 2'd1, 32'hFFFFFFFF, 32'd0, data, lat);
    check("s5_ram_a0", 32'(trace_a[0]), 32'h1FFFF);
    check("s5_ram_a1", 32'(trace_a[1]), 32'h0);
    check("s5_data", data, 32'h0000BC9A);
    check("s5_lat", 32'(lat), 32'd4);

    // 6: reset in the middle of a word write.
    @(negedge clk);
    mm_mct_e = 1'b1; mm_mct_wr = 1'b1; mm_mct_cu = 2'd3; mm_mct_a = 32'h300;
    mm_mct_n_i = 32'hCAFEF00D;
    @(negedge clk);
    check("s6_wr_c0", 32'(ram_wr), 32'd1);
    @(negedge clk);
    check("s6_wr_c1", 32'(ram_wr), 32'd1);
    check("s6_a_c1", 32'(ram_a), 32'h301);
    rst = 1'b1;
    #1;
    check("s6_rst_wr", 32'(ram_wr), 32'd0);
    check("s6_rst_a", 32'(ram_a), 32'd0);
    check("s6_rst_dout", 32'(ram_dout), 32'd0);
    check("s6_rst_ok", 32'({if_mct_ok, mm_mct_ok}), 32'd0);
    mm_mct_e = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    shadow[32'h300] = 8'h0D;
    repeat (8) begin
      @(negedge clk);
      check("s6_no_ok", 32'({if_mct_ok, mm_mct_ok}), 32'd0);
    end
    check("s6_mem301", 32'(ram[32'h301]), 32'(shadow[32'h301]));
    model_txn("s6_read", 1'b0, 1'b0, 2'd3, 32'h300, 32'd0);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      ram[32'h200 + i]    = 8'(i + 1);
      shadow[32'h200 + i] = 8'(i + 1);
    end
    vecs[0] = '{1'b0, 1'b0, 2'd3, 32'h200, 32'h0,        32'h04030201, 6};
    vecs[1] = '{1'b0, 1'b0, 2'd0, 32'h203, 32'h0,        32'h00000004, 3};
    vecs[2] = '{1'b0, 1'b0, 2'd1, 32'h205, 32'h0,        32'h00000706, 4};
    vecs[3] = '{1'b0, 1'b1, 2'd1, 32'h200, 32'h1234ABCD, 32'h0,        3};
    vecs[4] = '{1'b0, 1'b0, 2'd3, 32'h200, 32'h0,        32'h0403ABCD, 6};
    vecs[5] = '{1'b1, 1'b0, 2'd3, 32'h204, 32'h0,        32'h08070605, 6};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 32'h204, 32'hDEADBEEF, 32'h0,        5};
    vecs[7] = '{1'b1, 1'b0, 2'd3, 32'h202, 32'h0,        32'hBEEF0403, 6};
    vecs[8] = '{1'b0, 1'b1, 2'd0, 32'h207, 32'h00000055, 32'h0,        2};
    vecs[9] = '{1'b0, 1'b0, 2'd3, 32'h204, 32'h0,        32'h55ADBEEF, 6};
    foreach (vecs[i]) begin
      run_txn(vecs[i].is_if, vecs[i].wr, vecs[i].cu, vecs[i].addr, vecs[i].wdata, data, lat);
      if (!vecs[i].is_if && vecs[i].wr)
        model_write(vecs[i].addr, nbytes(vecs[i].cu), vecs[i].wdata);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Random traffic against the shadow-memory model.
    for (int t = 0; t < 150; t++) begin
      int kind;
      logic [1:0] cu;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       cu = 2'd0;
        1:       cu = 2'd1;
        default: cu = 2'd3;
      endcase
      addr = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
      model_txn($sformatf("rnd%0d", t), kind == 0, kind == 2, cu, addr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
